// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_a;
    logic                 r_neg_b;
    logic [WIDTH-1:0]     r_ua;
    logic [WIDTH-1:0]     r_ub;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_signed;
    logic                 w_neg_a_in;
    logic                 w_neg_b_in;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_div_trial;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_a_orig;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Operand magnitudes and signs; unsigned ops pass operands through untouched
    always_comb begin
        w_signed   = ~i_op[0];
        w_neg_a_in = w_signed & i_a[WIDTH-1];
        w_neg_b_in = w_signed & i_b[WIDTH-1];
        w_abs_a    = w_neg_a_in ? -i_a : i_a;
        w_abs_b    = w_neg_b_in ? -i_b : i_b;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_ua} : '0);
        w_mul_step  = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_ub};
        if (!w_div_trial[WIDTH])
            w_div_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
            w_div_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end

    // Sign correction and divide-by-zero substitution for the final write
    always_comb begin
        w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
        w_a_orig = r_neg_a ? -r_ua : r_ua;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_ub == '0) begin
                w_res_hi = w_a_orig;
                w_res_lo = '1;
            end else begin
                w_res_lo = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_res_hi = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Next-state logic and busy flag
    always_comb begin
        w_next = r_state;
        o_busy = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Datapath: operand capture, iteration, HI/LO writes and done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_ua     <= '0;
            r_ub     <= '0;
            r_acc    <= '0;
            o_hi     <= '0;
            o_lo     <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (i_hi_we) o_hi <= i_a;
                    if (i_lo_we) o_lo <= i_a;
                    if (i_start) begin
                        r_is_div <= i_op[1];
                        r_neg_a  <= w_neg_a_in;
                        r_neg_b  <= w_neg_b_in;
                        r_ua     <= w_abs_a;
                        r_ub     <= w_abs_b;
                        r_acc    <= i_op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
                        r_cnt    <= CNT_W'(WIDTH);
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    o_hi <= w_res_hi;
                    o_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed vector bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; presents the op, then waits for done.
    // Returns at the negedge where done is first seen high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output int busy_cnt);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0F0F_F0F0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        logic [31:0] hold_hi;

        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{"mult_neg3x7", OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{"div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4]  = '{"div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{"divu_by0",    OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[6]  = '{"div_by0_neg", OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7]  = '{"mult_m1_m1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{"mult_minmin", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{"multu_2p16",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{"div_7_m2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{"div_m7_m2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hi",   hi, 32'h0);
        chk("reset_lo",   lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk({vecs[i].name, "_lat"},  lat, 32'd33);
            chk({vecs[i].name, "_busy"}, bcnt, 32'd33);
            chk({vecs[i].name, "_hi"},   hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"},   lo, vecs[i].exp_lo);
            @(negedge clk);
            chk({vecs[i].name, "_done1"}, {31'b0, done}, 32'h0);
        end

        // MTHI, MTLO, and both together in IDLE
        hi_we = 1'b1; a = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", hi, 32'h0000_1234);
        lo_we = 1'b1; a = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h0000_5678);
        hi_we = 1'b1; lo_we = 1'b1; a = 32'hCAFE_BABE;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo_hi", hi, 32'hCAFE_BABE);
        chk("mthilo_lo", lo, 32'hCAFE_BABE);

        // start and hi_we during busy are ignored; hi holds during the run
        hold_hi = hi;
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; a = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_hold_hi", hi, hold_hi);
        chk("busy_flag", {31'b0, busy}, 32'h1);
        lat = 6;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", lat, 32'd33);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);

        // Back-to-back: second start on the done cycle
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        chk("b2b_first_lo", lo, 32'hFFFF_FFEB);
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        chk("b2b_lat", lat, 32'd33);
        chk("b2b_hi", hi, 32'd2);
        chk("b2b_lo", lo, 32'd14);

        // Reset in the middle of a MULT abandons it
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done || busy) bcnt++;
        end
        chk("rst_no_done", bcnt, 32'd0);
        chk("rst_after_lo", lo, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
